dds_freq_meter: RTL

Measurement-side counterpart to the DDS generator: takes the DDS sample stream (one lane of `data_out`, offset-binary), detects rising midscale crossings with hysteresis over a fixed gate window, and reports the measured frequency in the same three-field MHz/kHz/Hz format used on the DDS frequency inputs (`fre_x`/`fre_y`/`fre_z`). It sits after the waveform ROM for closed-loop self-test: program a frequency, measure it back, compare the fields.

---
 rtl/dds_pkg.sv | 19 +
 rtl/schmitt_edge.sv | 48 ++++
 rtl/dds_freq_meter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared constants and state encoding for the DDS control and measurement paths.
// The MHz/kHz/Hz field split is common to the DDS frequency inputs and the
// frequency meter result, so the divisors live here once.
package dds_pkg;

    // Decimal weights of the MHz and kHz fields when expressed in Hz.
    localparam int unsigned ONE_M = 1_000_000;
    localparam int unsigned ONE_K = 1_000;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        CONV_M = 3'd2,
        CONV_K = 3'd3,
        DONE   = 3'd4
    } meter_state_t;

endpackage

// File: rtl/schmitt_edge.sv
// Hysteresis comparator around midscale for an offset-binary sample stream,
// plus a single-cycle pulse on each low-to-high transition of the tracked level.
// The pulse is combinational so that a crossing presented on a given cycle is
// visible to the consumer at the same clock edge that updates the level.
module schmitt_edge #(
    parameter int unsigned DATA_WIDTH_ROM = 8,
    parameter int unsigned HYST           = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH_ROM-1:0] sample_in,
    input  logic                      sample_vld,
    output logic                      lvl,
    output logic                      rise
);

    localparam int unsigned MID = 1 << (DATA_WIDTH_ROM - 1);
    // One extra bit so MID+HYST never wraps for the comparison.
    localparam logic [DATA_WIDTH_ROM:0] HI_TH = (DATA_WIDTH_ROM + 1)'(MID + HYST);
    localparam logic [DATA_WIDTH_ROM:0] LO_TH = (DATA_WIDTH_ROM + 1)'(MID - HYST);

    logic                    lvl_reg;
    logic [DATA_WIDTH_ROM:0] sample_ext;
    logic                    set_hit;
    logic                    clr_hit;

    // Threshold decisions, only meaningful on valid samples.
    always_comb begin
        sample_ext = {1'b0, sample_in};
        set_hit    = sample_vld && (sample_ext >= HI_TH);
        clr_hit    = sample_vld && (sample_ext <= LO_TH);
    end

    // Level tracker: set above the upper threshold, clear below the lower, hold between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_reg <= 1'b0;
        end else if (set_hit) begin
            lvl_reg <= 1'b1;
        end else if (clr_hit) begin
            lvl_reg <= 1'b0;
        end
    end

    assign lvl  = lvl_reg;
    assign rise = set_hit && !lvl_reg;

endmodule

// File: rtl/dds_freq_meter.sv
// Frequency meter for the DDS sample stream: counts rising midscale crossings
// over a fixed gate, then splits the count into MHz/kHz/Hz fields by repeated
// subtraction so the result can be compared directly with the programmed
// fre_x/fre_y/fre_z inputs of the generator.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_ROM = 8,
    parameter int unsigned FRE_WIDTH      = 10,
    parameter int unsigned HYST           = 8,
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned CNT_MAX        = 999_999_999
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH_ROM-1:0] sample_in,
    input  logic                      sample_vld,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [FRE_WIDTH-1:0]      fre_x,
    output logic [FRE_WIDTH-1:0]      fre_y,
    output logic [FRE_WIDTH-1:0]      fre_z,
    output logic                      overflow
);

    localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [29:0]       CNT_LIMIT = 30'(CNT_MAX);
    localparam logic [29:0]       STEP_M    = 30'(ONE_M);
    localparam logic [29:0]       STEP_K    = 30'(ONE_K);

    meter_state_t          state_reg, state_next;
    logic [29:0]           cnt_reg, cnt_next;
    logic [GATE_W-1:0]     gate_reg, gate_next;
    logic [29:0]           rem_reg, rem_next;
    logic [9:0]            x_reg, x_next;
    logic [9:0]            y_reg, y_next;
    logic                  sticky_reg, sticky_next;
    logic [FRE_WIDTH-1:0]  fre_x_reg, fre_x_next;
    logic [FRE_WIDTH-1:0]  fre_y_reg, fre_y_next;
    logic [FRE_WIDTH-1:0]  fre_z_reg, fre_z_next;
    logic                  ovf_reg, ovf_next;
    logic                  done_reg, done_next;

    logic                  lvl;
    logic                  rise;
    logic [29:0]           cnt_bumped;
    logic                  sat_hit;

    // Crossing detector runs in every state so the level is settled before the gate opens.
    schmitt_edge #(
        .DATA_WIDTH_ROM (DATA_WIDTH_ROM),
        .HYST           (HYST)
    ) u_schmitt (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .lvl        (lvl),
        .rise       (rise)
    );

    // Saturating increment of the crossing count for the current cycle's edge.
    always_comb begin
        cnt_bumped = cnt_reg;
        sat_hit    = 1'b0;
        if (rise) begin
            if (cnt_reg >= CNT_LIMIT) begin
                sat_hit = 1'b1;
            end else begin
                cnt_bumped = cnt_reg + 30'd1;
            end
        end
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        gate_next   = gate_reg;
        rem_next    = rem_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        sticky_next = sticky_reg;
        fre_x_next  = fre_x_reg;
        fre_y_next  = fre_y_reg;
        fre_z_next  = fre_z_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = GATE;
                    cnt_next    = '0;
                    gate_next   = '0;
                    sticky_next = 1'b0;
                    x_next      = '0;
                    y_next      = '0;
                end
            end
            GATE: begin
                cnt_next    = cnt_bumped;
                sticky_next = sticky_reg | sat_hit;
                gate_next   = gate_reg + GATE_W'(1);
                // The last gate cycle's crossing is folded straight into rem.
                if (gate_reg == GATE_LAST) begin
                    state_next = CONV_M;
                    rem_next   = cnt_bumped;
                end
            end
            CONV_M: begin
                if (rem_reg >= STEP_M) begin
                    rem_next = rem_reg - STEP_M;
                    x_next   = x_reg + 10'd1;
                end else begin
                    state_next = CONV_K;
                end
            end
            CONV_K: begin
                if (rem_reg >= STEP_K) begin
                    rem_next = rem_reg - STEP_K;
                    y_next   = y_reg + 10'd1;
                end else begin
                    // Results are published on the edge that enters DONE.
                    state_next = DONE;
                    fre_x_next = FRE_WIDTH'(x_reg);
                    fre_y_next = FRE_WIDTH'(y_reg);
                    fre_z_next = FRE_WIDTH'(rem_reg);
                    ovf_next   = sticky_reg;
                    done_next  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any measurement in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            gate_reg   <= '0;
            rem_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            sticky_reg <= 1'b0;
            fre_x_reg  <= '0;
            fre_y_reg  <= '0;
            fre_z_reg  <= '0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            gate_reg   <= gate_next;
            rem_reg    <= rem_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            sticky_reg <= sticky_next;
            fre_x_reg  <= fre_x_next;
            fre_y_reg  <= fre_y_next;
            fre_z_reg  <= fre_z_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign fre_x    = fre_x_reg;
    assign fre_y    = fre_y_reg;
    assign fre_z    = fre_z_reg;
    assign overflow = ovf_reg;

endmodule
